// File: rtl/sha1_pkg.sv
// sha1_pkg: constants and types shared by the SHA-1 message padder.
package sha1_pkg;
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_BYTES = 64;
    localparam int LEN_POS     = 56;
    typedef enum logic [2:0] {FILL, PAD, LOAD, START, WAIT} state_e;
endpackage

// File: rtl/sha1_block_buf.sv
// sha1_block_buf: 64-byte block register file with byte, marker and length writes.
module sha1_block_buf
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        wr_en_i,
    input  logic [5:0]  wr_idx_i,
    input  logic [7:0]  wr_data_i,
    input  logic        mk_en_i,
    input  logic [5:0]  mk_idx_i,
    input  logic        len_en_i,
    input  logic [63:0] len_i,
    input  logic [3:0]  rd_word_i,
    output logic [31:0] rd_data_o
);
    logic [7:0] mem_q [BLOCK_BYTES];
    logic [7:0] mem_d [BLOCK_BYTES];

    always_comb begin
        mem_d = mem_q;
        if (clr_i) mem_d = '{default: 8'h00};
        if (wr_en_i) mem_d[wr_idx_i] = wr_data_i;
        if (mk_en_i) mem_d[mk_idx_i] = 8'h80;
        // Bit length lands big-endian in the last eight bytes (words 14-15).
        if (len_en_i) for (int k = 0; k < 8; k++) mem_d[6'(LEN_POS + k)] = len_i[63 - 8*k -: 8];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) mem_q <= '{default: 8'h00};
        else       mem_q <= mem_d;

    assign rd_data_o = {mem_q[{rd_word_i, 2'd0}], mem_q[{rd_word_i, 2'd1}],
                        mem_q[{rd_word_i, 2'd2}], mem_q[{rd_word_i, 2'd3}]};
endmodule

// File: rtl/sha1_padder.sv
// sha1_padder: builds padded SHA-1 blocks from a byte stream and feeds them to sha1_exec.
module sha1_padder
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         load_in,
    output logic [31:0]  data_in,
    output logic         start,
    output logic [159:0] cv,
    output logic         use_prev_cv,
    input  logic         busy,
    input  logic         out_valid,
    output logic         msg_done
);
    localparam int CW = $clog2(BLOCK_WORDS);

    state_e        state_q;
    logic [6:0]    idx_q;
    logic [60:0]   len_q;
    logic [CW-1:0] cnt_q;
    logic          need_80_q, need_len_q, fin_q, first_q;
    logic          start_q, upc_q, done_q;
    logic          acc, mk, lw, clr;
    logic [6:0]    pos;
    logic [31:0]   rd;

    assign in_ready    = (state_q == FILL) & ~reset;
    assign acc         = in_valid & in_ready;
    assign load_in     = (state_q == LOAD) & ~busy;
    assign data_in     = load_in ? rd : '0;
    assign start       = start_q;
    assign use_prev_cv = upc_q;
    assign msg_done    = done_q;
    assign cv          = IV;
    // idx==64 means the last byte filled the block; the marker waits for a fresh block.
    assign mk  = (state_q == PAD) & need_80_q & ~idx_q[6];
    assign pos = idx_q + {6'd0, mk};
    assign lw  = (state_q == PAD) & need_len_q & (pos <= 7'(LEN_POS));
    assign clr = (state_q == WAIT) & out_valid;

    sha1_block_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (clr),
        .wr_en_i   (acc),
        .wr_idx_i  (idx_q[5:0]),
        .wr_data_i (in_data),
        .mk_en_i   (mk),
        .mk_idx_i  (idx_q[5:0]),
        .len_en_i  (lw),
        .len_i     ({len_q, 3'b000}),
        .rd_word_i (cnt_q),
        .rd_data_o (rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            need_80_q  <= 1'b0;
            need_len_q <= 1'b0;
            fin_q      <= 1'b0;
            first_q    <= 1'b1;
            start_q    <= 1'b0;
            upc_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            upc_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                FILL: if (acc) begin
                    idx_q <= idx_q + 7'd1;
                    len_q <= len_q + 61'd1;
                    if (in_last) begin
                        need_80_q  <= 1'b1;
                        need_len_q <= 1'b1;
                        fin_q      <= 1'b1;
                        state_q    <= PAD;
                    end else if (idx_q == 7'd63) state_q <= LOAD;
                end
                PAD: begin
                    if (mk) need_80_q <= 1'b0;
                    if (lw) need_len_q <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: if (!busy) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
                        start_q <= 1'b1;
                        upc_q   <= ~first_q;
                        state_q <= START;
                    end
                end
                START: begin
                    first_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: if (out_valid) begin
                    idx_q <= '0;
                    if (need_80_q | need_len_q) state_q <= PAD;
                    else begin
                        state_q <= FILL;
                        if (fin_q) begin
                            done_q  <= 1'b1;
                            first_q <= 1'b1;
                            len_q   <= '0;
                            fin_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_padder.sv
// tb_sha1_padder: scoreboard bench for sha1_padder with a simple core model.
module tb_sha1_padder;
    logic         clk = 0, reset = 1, in_valid = 0, in_last = 0;
    logic         ext_busy = 0, core_busy = 0, out_valid = 0;
    logic [7:0]   in_data = 0;
    logic         in_ready, load_in, start, use_prev_cv, msg_done, busy;
    logic [31:0]  data_in;
    logic [159:0] cv;

    assign busy = ext_busy | core_busy;

    sha1_padder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .load_in(load_in), .data_in(data_in),
        .start(start), .cv(cv), .use_prev_cv(use_prev_cv), .busy(busy),
        .out_valid(out_valid), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_w[$];
    logic        exp_u[$];
    logic [31:0] cap[$];
    int exp_done = 0, got_done = 0;
    int ref_cyc = -1, ref_off = 0, ov_cyc = -1, acc_n = 0;
    bit tchk = 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic push_exp(input logic [7:0] m[$]);
        logic [7:0]  p[$];
        logic [63:0] bl;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int k = 0; k < 8; k++) p.push_back(bl[63 - 8*k -: 8]);
        for (int i = 0; i < p.size(); i += 4) exp_w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        for (int b = 0; b < p.size() / 64; b++) exp_u.push_back(b != 0);
    endtask

    task automatic send(input logic [7:0] m[$]);
        int w;
        for (int i = 0; i < m.size(); i++) begin
            in_valid = 1;
            in_data  = m[i];
            in_last  = (i == m.size() - 1);
            w = 0;
            while (!in_ready && w < 3000) begin @(negedge clk); w++; end
            if (!in_ready) chk("in_ready_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic run_msg(input logic [7:0] m[$]);
        int w;
        push_exp(m);
        exp_done++;
        send(m);
        w = 0;
        while (got_done != exp_done && w < 3000) begin @(negedge clk); w++; end
        if (got_done != exp_done) chk("done_timeout", got_done, exp_done);
    endtask

    always @(negedge clk) if (!reset) begin
        if (in_valid && in_ready) begin
            acc_n++;
            if (in_last) begin ref_cyc = cyc; ref_off = 18; acc_n = 0; end
            else if (acc_n % 64 == 0) begin ref_cyc = cyc; ref_off = 17; end
        end
        if (load_in) begin
            chk("in_ready_in_load", in_ready, 0);
            chk("load_while_busy", busy, 0);
            if (exp_w.size() == 0) chk("load_extra", load_in, 0);
            else begin
                chk("data_in", data_in, exp_w.pop_front());
                cap.push_back(data_in);
            end
        end
        if (start) begin
            chk("in_ready_in_start", in_ready, 0);
            if (exp_u.size() == 0) chk("start_extra", start, 0);
            else chk("use_prev_cv", use_prev_cv, exp_u.pop_front());
            if (tchk && ref_cyc >= 0) chk("start_latency", cyc - ref_cyc, ref_off);
            ref_cyc = -1;
        end
        if (msg_done) begin
            got_done++;
            chk("done_latency", cyc - ov_cyc, 1);
            chk("in_ready_at_done", in_ready, 1);
            chk("done_not_expected", got_done <= exp_done, 1);
        end
    end

    initial forever begin
        @(negedge clk);
        if (start && !reset) begin
            core_busy = 1;
            repeat (12) @(negedge clk);
            if (!reset) begin
                out_valid = 1;
                ov_cyc = cyc;
                @(negedge clk);
                out_valid = 0;
            end
            core_busy = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] m[$];
        string s;
        int b, w, n;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_load_in", load_in, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_start", start, 0);
        chk("rst_use_prev_cv", use_prev_cv, 0);
        chk("rst_msg_done", msg_done, 0);
        reset = 0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("cv_iv", cv, 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0);

        m = '{8'h61, 8'h62, 8'h63};
        b = cap.size();
        run_msg(m);
        chk("abc_nwords", cap.size() - b, 16);
        chk("abc_w0", cap[b], 32'h61626380);
        chk("abc_w14", cap[b+14], 32'h0);
        chk("abc_w15", cap[b+15], 32'h18);

        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        m = {};
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
        b = cap.size();
        run_msg(m);
        chk("m56_nwords", cap.size() - b, 32);
        chk("m56_w14", cap[b+14], 32'h80000000);
        chk("m56_w31", cap[b+31], 32'h1C0);

        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'h61);
        b = cap.size();
        run_msg(m);
        chk("a55_nwords", cap.size() - b, 16);
        chk("a55_w13", cap[b+13], 32'h61616180);
        chk("a55_w15", cap[b+15], 32'h1B8);

        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'h61);
        b = cap.size();
        run_msg(m);
        chk("a64_nwords", cap.size() - b, 32);
        chk("a64_w16", cap[b+16], 32'h80000000);
        chk("a64_w31", cap[b+31], 32'h200);

        // 70 bytes: in_valid stays high through LOAD/START/WAIT of block 0.
        m = {};
        for (int i = 0; i < 70; i++) m.push_back(8'(i + 1));
        b = cap.size();
        run_msg(m);
        chk("m70_nwords", cap.size() - b, 32);
        chk("m70_w16", cap[b+16], 32'h41424344);
        chk("m70_w17", cap[b+17], 32'h45468000);
        chk("m70_w31", cap[b+31], 32'h230);

        m = '{8'h61, 8'h62, 8'h63};
        b = cap.size();
        push_exp(m);
        send(m);
        w = 0;
        while (cap.size() < b + 7 && w < 200) begin @(negedge clk); w++; end
        chk("rst_mid_reached", cap.size() >= b + 7, 1);
        #1 reset = 1;
        #1;
        chk("rst_mid_load_in", load_in, 0);
        chk("rst_mid_data_in", data_in, 0);
        chk("rst_mid_start", start, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_msg_done", msg_done, 0);
        exp_w.delete();
        exp_u.delete();
        n = cap.size();
        @(negedge clk);
        reset = 0;
        repeat (30) @(negedge clk);
        chk("rst_no_more_load", cap.size(), n);

        m = '{8'h61, 8'h62, 8'h63};
        b = cap.size();
        run_msg(m);
        chk("abc2_w0", cap[b], 32'h61626380);
        chk("abc2_w15", cap[b+15], 32'h18);

        // Core busy before load: padder must hold off load_in.
        tchk = 0;
        ext_busy = 1;
        b = cap.size();
        fork
            run_msg(m);
            begin
                repeat (30) @(negedge clk);
                chk("stall_no_load", cap.size(), b);
                ext_busy = 0;
            end
        join
        chk("stall_nwords", cap.size() - b, 16);
        chk("stall_w0", cap[b], 32'h61626380);
        tchk = 1;

        repeat (5) @(negedge clk);
        chk("msgs_done", got_done, exp_done);
        chk("words_left", exp_w.size(), 0);
        chk("starts_left", exp_u.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
